// File: rtl/async_fifo_pkg.sv
// Shared async-FIFO helpers: pointer geometry and Gray/binary conversion,
// used by both the write- and read-side pointer handlers.
package async_fifo_pkg;

    localparam int unsigned CODE_W = 32;

    function automatic int unsigned fifo_depth(input int unsigned addr_size);
        return 32'd1 << addr_size;
    endfunction

    // One extra pointer bit distinguishes full from empty when the address bits match.
    function automatic int unsigned ptr_width(input int unsigned addr_size);
        return addr_size + 32'd1;
    endfunction

    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
        logic [CODE_W-1:0] b;
        b = '0;
        for (int i = 0; i < CODE_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/write_pointer_ctrl_v2_gray_to_bin.sv
// Combinational Gray-to-binary converter for a synchronised pointer.
module gray_to_bin
    import async_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 9
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    assign o_bin = WIDTH'(gray2bin(CODE_W'(i_gray)));

endmodule

// File: rtl/write_pointer_ctrl_v2.sv
// Write-side pointer handler of an async FIFO: binary/Gray write pointer,
// registered full / almost-full / level flags and a sticky overflow flag.
module write_pointer_ctrl_v2
    import async_fifo_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned AF_RESET  = (32'd1 << ADDR_SIZE) - 32'd2
) (
    input  logic               wclk,
    input  logic               wrst_n,
    input  logic               wr_en,
    input  logic [ADDR_SIZE:0] g_r_ptr_sync,
    input  logic               af_thresh_wr,
    input  logic [ADDR_SIZE:0] af_thresh,
    input  logic               ovf_clr,
    output logic [ADDR_SIZE:0] b_w_ptr,
    output logic [ADDR_SIZE:0] g_w_ptr,
    output logic               wr_ack,
    output logic               full,
    output logic               almost_full,
    output logic [ADDR_SIZE:0] wr_level,
    output logic               overflow
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_SIZE);
    localparam int unsigned PTR_W = ptr_width(ADDR_SIZE);

    logic [PTR_W-1:0] r_b_w_ptr;
    logic [PTR_W-1:0] r_g_w_ptr;
    logic             r_wr_ack;
    logic             r_full;
    logic             r_almost_full;
    logic [PTR_W-1:0] r_wr_level;
    logic             r_overflow;
    logic [PTR_W-1:0] r_thr;

    logic             w_accept;
    logic [PTR_W-1:0] w_b_next;
    logic [PTR_W-1:0] w_b_r;
    logic [PTR_W-1:0] w_level_next;
    logic             w_full_next;
    logic             w_af_next;
    logic [PTR_W-1:0] w_thr_load;

    gray_to_bin #(
        .WIDTH (PTR_W)
    ) u_rptr_g2b (
        .i_gray (g_r_ptr_sync),
        .o_bin  (w_b_r)
    );

    assign w_accept     = wr_en & ~r_full;
    assign w_b_next     = r_b_w_ptr + {{ADDR_SIZE{1'b0}}, w_accept};
    assign w_level_next = w_b_next - w_b_r;
    assign w_full_next  = (w_b_next[ADDR_SIZE] != w_b_r[ADDR_SIZE]) &&
                          (w_b_next[ADDR_SIZE-1:0] == w_b_r[ADDR_SIZE-1:0]);
    assign w_af_next    = (w_level_next >= r_thr);

    // A threshold of zero or beyond the FIFO depth is meaningless; pin it to DEPTH.
    assign w_thr_load = ((af_thresh == '0) || (af_thresh > PTR_W'(DEPTH))) ?
                        PTR_W'(DEPTH) : af_thresh;

    // Flags are recomputed every edge so read progress alone can release full.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_b_w_ptr     <= '0;
            r_g_w_ptr     <= '0;
            r_wr_ack      <= 1'b0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_wr_level    <= '0;
            r_overflow    <= 1'b0;
            r_thr         <= PTR_W'(AF_RESET);
        end else begin
            r_b_w_ptr     <= w_b_next;
            r_g_w_ptr     <= PTR_W'(bin2gray(CODE_W'(w_b_next)));
            r_wr_ack      <= w_accept;
            r_full        <= w_full_next;
            r_almost_full <= w_af_next;
            r_wr_level    <= w_level_next;
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
            if (af_thresh_wr) begin
                r_thr <= w_thr_load;
            end
        end
    end

    assign b_w_ptr     = r_b_w_ptr;
    assign g_w_ptr     = r_g_w_ptr;
    assign wr_ack      = r_wr_ack;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign wr_level    = r_wr_level;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_write_pointer_ctrl_v2.sv
// Directed bench for write_pointer_ctrl_v2 with ADDR_SIZE=3 (DEPTH=8), AF_RESET=6.
module tb_write_pointer_ctrl_v2;

    logic       wclk;
    logic       wrst_n;
    logic       wr_en;
    logic [3:0] g_r_ptr_sync;
    logic       af_thresh_wr;
    logic [3:0] af_thresh;
    logic       ovf_clr;
    logic [3:0] b_w_ptr;
    logic [3:0] g_w_ptr;
    logic       wr_ack;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_level;
    logic       overflow;

    int n_pass;
    int n_total;

    write_pointer_ctrl_v2 #(
        .ADDR_SIZE (3),
        .AF_RESET  (6)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .wr_en        (wr_en),
        .g_r_ptr_sync (g_r_ptr_sync),
        .af_thresh_wr (af_thresh_wr),
        .af_thresh    (af_thresh),
        .ovf_clr      (ovf_clr),
        .b_w_ptr      (b_w_ptr),
        .g_w_ptr      (g_w_ptr),
        .wr_ack       (wr_ack),
        .full         (full),
        .almost_full  (almost_full),
        .wr_level     (wr_level),
        .overflow     (overflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        wrst_n = 1'b0; wr_en = 1'b1; g_r_ptr_sync = 4'd0;
        af_thresh_wr = 1'b0; af_thresh = 4'd0; ovf_clr = 1'b0;
        tick(); tick();
        n_total++; if ({b_w_ptr, g_w_ptr, wr_level} !== 12'h000) $display("FAIL reset_ptrs got b=%b g=%b lvl=%0d want 0", b_w_ptr, g_w_ptr, wr_level); else n_pass++;
        n_total++; if ({wr_ack, full, almost_full, overflow} !== 4'b0000) $display("FAIL reset_flags got ack/full/af/ovf=%b want 0000", {wr_ack, full, almost_full, overflow}); else n_pass++;
    endtask

    task automatic test_fill();
        int acks;
        logic [3:0] exp_lvl;
        acks = 0;
        wrst_n = 1'b1; wr_en = 1'b1; g_r_ptr_sync = 4'd0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_lvl = (k <= 8) ? 4'(k) : 4'd8;
            if (wr_ack === 1'b1) acks++;
            n_total++; if (wr_ack !== (k <= 8)) $display("FAIL fill_ack[%0d] got %b want %b", k, wr_ack, (k <= 8)); else n_pass++;
            n_total++; if (wr_level !== exp_lvl) $display("FAIL fill_level[%0d] got %0d want %0d", k, wr_level, exp_lvl); else n_pass++;
            n_total++; if (almost_full !== (exp_lvl >= 4'd6)) $display("FAIL fill_af[%0d] got %b want %b", k, almost_full, (exp_lvl >= 4'd6)); else n_pass++;
            n_total++; if (full !== (k >= 8)) $display("FAIL fill_full[%0d] got %b want %b", k, full, (k >= 8)); else n_pass++;
            n_total++; if (overflow !== (k >= 9)) $display("FAIL fill_ovf[%0d] got %b want %b", k, overflow, (k >= 9)); else n_pass++;
        end
        wr_en = 1'b0;
        n_total++; if (acks != 8) $display("FAIL fill_ack_count got %0d want 8", acks); else n_pass++;
        n_total++; if (b_w_ptr !== 4'd8) $display("FAIL fill_bptr got %0d want 8", b_w_ptr); else n_pass++;
        n_total++; if (g_w_ptr !== 4'b1100) $display("FAIL fill_gptr got %b want 1100", g_w_ptr); else n_pass++;
    endtask

    task automatic test_drain_release();
        g_r_ptr_sync = 4'b0001;
        tick();
        n_total++; if (full !== 1'b0) $display("FAIL drain_full got %b want 0", full); else n_pass++;
        n_total++; if (wr_level !== 4'd7) $display("FAIL drain_level got %0d want 7", wr_level); else n_pass++;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        n_total++; if (wr_ack !== 1'b1) $display("FAIL drain_ack got %b want 1", wr_ack); else n_pass++;
        n_total++; if (b_w_ptr !== 4'd9) $display("FAIL drain_bptr got %0d want 9", b_w_ptr); else n_pass++;
        n_total++; if (full !== 1'b1 || wr_level !== 4'd8) $display("FAIL drain_refill got full=%b lvl=%0d want 1/8", full, wr_level); else n_pass++;
    endtask

    task automatic test_overflow_clear();
        wr_en = 1'b1; ovf_clr = 1'b1;
        tick();
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins got %b want 1", overflow); else n_pass++;
        n_total++; if (b_w_ptr !== 4'd9 || wr_ack !== 1'b0) $display("FAIL ovf_ptr_hold got b=%0d ack=%b want 9/0", b_w_ptr, wr_ack); else n_pass++;
        wr_en = 1'b0;
        tick();
        ovf_clr = 1'b0;
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [3:0] rd_gray [7];
        logic [3:0] exp_gray [7];
        logic [3:0] exp_b;
        rd_gray  = '{4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        exp_gray = '{4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        g_r_ptr_sync = 4'b1101;
        tick();
        n_total++; if (wr_level !== 4'd0 || full !== 1'b0) $display("FAIL wrap_start got lvl=%0d full=%b want 0/0", wr_level, full); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            g_r_ptr_sync = rd_gray[i]; wr_en = 1'b1;
            tick();
            exp_b = 4'(10 + i);
            n_total++; if (g_w_ptr !== exp_gray[i] || b_w_ptr !== exp_b) $display("FAIL wrap_ptr[%0d] got b=%0d g=%b want b=%0d g=%b", i, b_w_ptr, g_w_ptr, exp_b, exp_gray[i]); else n_pass++;
            n_total++; if (wr_level !== 4'd1 || full !== 1'b0) $display("FAIL wrap_flags[%0d] got lvl=%0d full=%b want 1/0", i, wr_level, full); else n_pass++;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_threshold();
        logic [3:0] exp_lvl;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        n_total++; if (wr_level !== 4'd2 || almost_full !== 1'b0) $display("FAIL thr_pre got lvl=%0d af=%b want 2/0", wr_level, almost_full); else n_pass++;
        af_thresh_wr = 1'b1; af_thresh = 4'd3;
        tick();
        af_thresh_wr = 1'b0;
        tick();
        n_total++; if (almost_full !== 1'b0) $display("FAIL thr3_level2 got %b want 0", almost_full); else n_pass++;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        n_total++; if (wr_level !== 4'd3 || almost_full !== 1'b1) $display("FAIL thr3_level3 got lvl=%0d af=%b want 3/1", wr_level, almost_full); else n_pass++;
        af_thresh_wr = 1'b1; af_thresh = 4'd0;
        tick();
        af_thresh_wr = 1'b0;
        tick();
        n_total++; if (almost_full !== 1'b0) $display("FAIL thr0_clamp got %b want 0", almost_full); else n_pass++;
        for (int k = 4; k <= 8; k++) begin
            wr_en = 1'b1;
            tick();
            exp_lvl = 4'(k);
            n_total++; if (wr_level !== exp_lvl || almost_full !== (k == 8)) $display("FAIL thr8_fill[%0d] got lvl=%0d af=%b want %0d/%b", k, wr_level, almost_full, exp_lvl, (k == 8)); else n_pass++;
        end
        wr_en = 1'b0;
        n_total++; if (full !== 1'b1) $display("FAIL thr8_full got %b want 1", full); else n_pass++;
    endtask

    task automatic test_reset_midop();
        logic [3:0] exp_lvl;
        wrst_n = 1'b0; wr_en = 1'b1; af_thresh_wr = 1'b1; af_thresh = 4'd2;
        tick();
        n_total++; if ({b_w_ptr, g_w_ptr, wr_level} !== 12'h000 || {wr_ack, full, almost_full, overflow} !== 4'b0000) $display("FAIL midreset got b=%0d g=%b lvl=%0d flags=%b want all 0", b_w_ptr, g_w_ptr, wr_level, {wr_ack, full, almost_full, overflow}); else n_pass++;
        wrst_n = 1'b1; af_thresh_wr = 1'b0; g_r_ptr_sync = 4'd0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_lvl = 4'(k);
            n_total++; if (wr_ack !== 1'b1 || b_w_ptr !== exp_lvl) $display("FAIL postreset_write[%0d] got ack=%b b=%0d want 1/%0d", k, wr_ack, b_w_ptr, exp_lvl); else n_pass++;
            n_total++; if (almost_full !== (k >= 6)) $display("FAIL postreset_thr6[%0d] got af=%b want %b", k, almost_full, (k >= 6)); else n_pass++;
        end
        wr_en = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_fill();
        test_drain_release();
        test_overflow_clear();
        test_wrap();
        test_threshold();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
